// File: rtl/ospi_pkg.sv
// ospi_pkg: op encoding, flash opcodes and FSM states shared by the OSPI command sequencer.
package ospi_pkg;
  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_ERASE   = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;
  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN,
    S_GAP_WREN,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_RESP,
    S_GAP
  } state_e;
  localparam logic [7:0] OPC_READ  = 8'h0B;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_ERASE = 8'h20;
  localparam logic [7:0] OPC_WREN  = 8'h06;
  localparam int CNT_W = 8;
  function automatic logic [7:0] opcode_of(op_e op);
    return op == OP_READ ? OPC_READ : op == OP_WRITE ? OPC_WRITE : OPC_ERASE;
  endfunction
endpackage

// File: rtl/ospi_cmd_sequencer_if.sv
// ospi_cmd_sequencer_if: host request/response port plus the octal-SPI pins.
interface ospi_cmd_sequencer_if #(parameter int ADDR_W = 24);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              resp_valid;
  logic [7:0]        resp_rdata;
  logic              resp_err;
  logic              ospi_clk;
  logic              ospi_cs;
  logic [7:0]        ospi_io_out;
  logic              ospi_io_oe;
  logic [7:0]        ospi_io_in;
  modport master (
    output req_valid, req_op, req_addr, req_wdata, ospi_io_in,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ospi_clk, ospi_cs, ospi_io_out, ospi_io_oe
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, ospi_io_in,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ospi_clk, ospi_cs, ospi_io_out, ospi_io_oe
  );
endinterface

// File: rtl/ospi_beat_timer.sv
// ospi_beat_timer: two-phase beat generator with a down-counter reloaded on every state change.
module ospi_beat_timer
  import ospi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             cyc_mode,
  input  logic             active,
  input  logic [CNT_W-1:0] load_cnt,
  output logic             phase,
  output logic             last_beat,
  output logic             ospi_clk
);
  logic [CNT_W-1:0] cnt;
  // cyc_mode counts plain clk cycles (CS gaps) with phase frozen low
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      phase <= 1'b0;
      cnt   <= load_cnt;
    end else begin
      phase <= !cyc_mode && !phase;
      if ((cyc_mode || phase) && cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  assign last_beat = cnt == '0;
  assign ospi_clk  = active && phase;
endmodule

// File: rtl/ospi_cmd_sequencer.sv
// ospi_cmd_sequencer: turns single-byte read/write/erase requests into octal-SPI SDR transactions.
module ospi_cmd_sequencer
  import ospi_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DUMMY_BEATS = 8,
  parameter int CS_GAP      = 2
) (
  input logic                clk,
  input logic                reset,
  ospi_cmd_sequencer_if.slave bus
);
  localparam int ADDR_BYTES = ADDR_W / 8;
  state_e            state, state_n;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q, rdata_q;
  logic              phase, last_beat, cyc_mode, adv, active, accept, wr_data, resp;
  logic [CNT_W-1:0]  load_cnt;
  assign accept   = state == S_IDLE && bus.req_valid;
  assign cyc_mode = state inside {S_IDLE, S_GAP_WREN, S_RESP, S_GAP};
  assign adv      = last_beat && (cyc_mode || phase);
  assign active   = state inside {S_WREN, S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign wr_data  = state == S_DATA && op_q == OP_WRITE;
  assign resp     = state == S_RESP;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (bus.req_valid) state_n = bus.req_op == OP_ILLEGAL ? S_RESP :
                                               bus.req_op == OP_READ ? S_CMD : S_WREN;
      S_WREN:     if (adv) state_n = S_GAP_WREN;
      S_GAP_WREN: if (adv) state_n = S_CMD;
      S_CMD:      if (adv) state_n = S_ADDR;
      S_ADDR:     if (adv) state_n = op_q == OP_ERASE ? S_RESP :
                                     (op_q == OP_WRITE || DUMMY_BEATS == 0) ? S_DATA : S_DUMMY;
      S_DUMMY:    if (adv) state_n = S_DATA;
      S_DATA:     if (adv) state_n = S_RESP;
      S_RESP:     state_n = (op_q == OP_ILLEGAL || CS_GAP < 2) ? S_IDLE : S_GAP;
      S_GAP:      if (adv) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end
  // RESP already provides one CS-high cycle, so GAP supplies the remaining CS_GAP-1
  assign load_cnt = state_n == S_GAP_WREN ? CNT_W'(CS_GAP - 1) :
                    state_n == S_ADDR     ? CNT_W'(ADDR_BYTES - 1) :
                    state_n == S_DUMMY    ? CNT_W'(DUMMY_BEATS - 1) :
                    state_n == S_GAP      ? CNT_W'(CS_GAP - 2) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q    <= op_e'(bus.req_op);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      if (state == S_ADDR && phase) addr_q <= addr_q << 8;
      if (state == S_DATA && phase && op_q == OP_READ) rdata_q <= bus.ospi_io_in;
    end
  ospi_beat_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_n != state),
    .cyc_mode (cyc_mode),
    .active   (active),
    .load_cnt (load_cnt),
    .phase    (phase),
    .last_beat(last_beat),
    .ospi_clk (bus.ospi_clk)
  );
  assign bus.ospi_cs     = !active;
  assign bus.ospi_io_oe  = state inside {S_WREN, S_CMD, S_ADDR} || wr_data;
  assign bus.ospi_io_out = state == S_WREN ? OPC_WREN :
                           state == S_CMD  ? opcode_of(op_q) :
                           state == S_ADDR ? addr_q[ADDR_W-1 -: 8] :
                           wr_data         ? wdata_q : 8'h00;
  assign bus.req_ready   = state == S_IDLE && !reset;
  assign bus.resp_valid  = resp;
  assign bus.resp_err    = resp && op_q == OP_ILLEGAL;
  assign bus.resp_rdata  = resp ? rdata_q : 8'h00;
endmodule

// File: tb/tb_ospi_cmd_sequencer.sv
// tb_ospi_cmd_sequencer: directed cycle-exact checks of pins and responses for each op and reset.
module tb_ospi_cmd_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  ospi_cmd_sequencer_if #(.ADDR_W(24)) bus ();
  ospi_cmd_sequencer #(.ADDR_W(24), .DUMMY_BEATS(8), .CS_GAP(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic pins(input string tag, input logic cs, input logic ck, input logic oe, input logic [7:0] d);
    chk({tag, " cs"}, 32'(bus.ospi_cs), 32'(cs));
    chk({tag, " sclk"}, 32'(bus.ospi_clk), 32'(ck));
    chk({tag, " oe"}, 32'(bus.ospi_io_oe), 32'(oe));
    chk({tag, " io_out"}, 32'(bus.ospi_io_out), 32'(d));
  endtask
  task automatic busy(input string tag);
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
  endtask
  task automatic beat(input string tag, input logic [7:0] d, input logic oe);
    tick;
    pins({tag, " ph0"}, 1'b0, 1'b0, oe, d);
    busy(tag);
    tick;
    pins({tag, " ph1"}, 1'b0, 1'b1, oe, d);
    busy(tag);
  endtask
  task automatic resp_tail(input string tag, input logic [7:0] rd, input logic err);
    tick;
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, " rdata"}, 32'(bus.resp_rdata), 32'(rd));
    chk({tag, " err"}, 32'(bus.resp_err), 32'(err));
    pins({tag, " resp"}, 1'b1, 1'b0, 1'b0, 8'h00);
    bus.ospi_io_in = 8'h00;
    tick;
    busy({tag, " gap"});
    chk({tag, " gap cs"}, 32'(bus.ospi_cs), 32'd1);
    tick;
    chk({tag, " ready again"}, 32'(bus.req_ready), 32'd1);
  endtask
  task automatic do_read(input logic [23:0] a, input logic [7:0] d, input logic hold);
    chk("rd accept ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_addr  = a;
    beat("rd cmd", 8'h0B, 1'b1);
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_addr  = 24'h0;
    end
    for (int i = 2; i >= 0; i--) beat("rd addr", a[8*i +: 8], 1'b1);
    for (int i = 0; i < 8; i++) beat("rd dummy", 8'h00, 1'b0);
    bus.ospi_io_in = d;
    beat("rd data", 8'h00, 1'b0);
    resp_tail("rd", d, 1'b0);
  endtask
  task automatic do_wr_er(input logic [1:0] op, input logic [23:0] a, input logic [7:0] d);
    chk("we accept ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
    beat("we wren", 8'h06, 1'b1);
    bus.req_valid = 1'b0;
    bus.req_addr  = 24'h0;
    bus.req_wdata = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick;
      pins("we cs gap", 1'b1, 1'b0, 1'b0, 8'h00);
      busy("we cs gap");
    end
    beat("we cmd", op == 2'd1 ? 8'h02 : 8'h20, 1'b1);
    for (int i = 2; i >= 0; i--) beat("we addr", a[8*i +: 8], 1'b1);
    if (op == 2'd1) beat("we data", d, 1'b1);
    resp_tail("we", 8'h00, 1'b0);
  endtask
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'd0;
    bus.req_addr   = 24'h0;
    bus.req_wdata  = 8'h00;
    bus.ospi_io_in = 8'h00;
    #1;
    pins("in reset", 1'b1, 1'b0, 1'b0, 8'h00);
    busy("in reset");
    chk("in reset rdata", 32'(bus.resp_rdata), 32'd0);
    chk("in reset err", 32'(bus.resp_err), 32'd0);
    tick;
    tick;
    reset = 1'b0;
    #1;
    do_read(24'h123456, 8'hA5, 1'b0);
    do_wr_er(2'd2, 24'hFF0000, 8'h00);
    do_wr_er(2'd1, 24'h000010, 8'h3C);
    chk("ill accept ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd3;
    tick;
    bus.req_valid = 1'b0;
    chk("ill resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("ill err", 32'(bus.resp_err), 32'd1);
    chk("ill rdata", 32'(bus.resp_rdata), 32'd0);
    pins("ill resp", 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    chk("ill ready", 32'(bus.req_ready), 32'd1);
    chk("ill resp gone", 32'(bus.resp_valid), 32'd0);
    pins("ill idle", 1'b1, 1'b0, 1'b0, 8'h00);
    do_read(24'hABCDEF, 8'h5A, 1'b1);
    tick;
    pins("b2b cmd ph0", 1'b0, 1'b0, 1'b1, 8'h0B);
    busy("b2b cmd");
    tick;
    pins("b2b cmd ph1", 1'b0, 1'b1, 1'b1, 8'h0B);
    bus.req_valid = 1'b0;
    beat("b2b addr", 8'hAB, 1'b1);
    reset = 1'b1;
    #1;
    pins("mid reset", 1'b1, 1'b0, 1'b0, 8'h00);
    busy("mid reset");
    tick;
    busy("held reset");
    reset = 1'b0;
    tick;
    chk("post reset ready", 32'(bus.req_ready), 32'd1);
    chk("post reset resp", 32'(bus.resp_valid), 32'd0);
    pins("post reset", 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    chk("post reset no resp", 32'(bus.resp_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
